// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative RV32M/RV64M multiply/divide unit.
// Op encoding follows RISC-V funct3; FSM state constants live here too.
package muldiv_pkg;

  localparam logic [2:0] OP_MUL    = 3'b000;
  localparam logic [2:0] OP_MULH   = 3'b001;
  localparam logic [2:0] OP_MULHSU = 3'b010;
  localparam logic [2:0] OP_MULHU  = 3'b011;
  localparam logic [2:0] OP_DIV    = 3'b100;
  localparam logic [2:0] OP_DIVU   = 3'b101;
  localparam logic [2:0] OP_REM    = 3'b110;
  localparam logic [2:0] OP_REMU   = 3'b111;

  typedef logic [1:0] state_t;

  localparam state_t S_IDLE = 2'd0;
  localparam state_t S_CALC = 2'd1;
  localparam state_t S_FIX  = 2'd2;

  function automatic logic is_div(input logic [2:0] op);
    return op[2];
  endfunction

  function automatic logic is_rem(input logic [2:0] op);
    return op[2] & op[1];
  endfunction

endpackage

// File: rtl/muldiv_sign_prep.sv
// Operand magnitude / sign / special-case decode, plus the final
// conditional negation applied when the result is produced.
module muldiv_sign_prep
  import muldiv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [2:0]        op,
  input  logic [XLEN-1:0]   data1,
  input  logic [XLEN-1:0]   data2,
  input  logic              neg_in,
  input  logic [2*XLEN-1:0] val_in,
  output logic [XLEN-1:0]   a_abs,
  output logic [XLEN-1:0]   b_abs,
  output logic              neg,
  output logic              dz,
  output logic              ovf,
  output logic              mz,
  output logic [2*XLEN-1:0] val_out
);

  localparam logic [XLEN-1:0] MIN = {1'b1, {(XLEN-1){1'b0}}};

  logic a_sgn;
  logic b_sgn;
  logic a_neg;
  logic b_neg;

  always_comb begin
    a_sgn = (op == OP_MULH) || (op == OP_MULHSU) ||
            (op == OP_DIV)  || (op == OP_REM);
    b_sgn = (op == OP_MULH) || (op == OP_DIV) ||
            (op == OP_REM);
    a_neg = a_sgn & data1[XLEN-1];
    b_neg = b_sgn & data2[XLEN-1];
    a_abs = a_neg ? -data1 : data1;
    b_abs = b_neg ? -data2 : data2;
    neg   = 1'b0;
    // Remainder follows the dividend's sign only.
    unique case (1'b1)
      (op == OP_MULH) || (op == OP_DIV):
        neg = a_neg ^ b_neg;
      (op == OP_MULHSU) || (op == OP_REM):
        neg = a_neg;
      default:
        neg = 1'b0;
    endcase
    dz  = is_div(op) && (data2 == '0);
    ovf = is_div(op) && b_sgn &&
          (data1 == MIN) && (data2 == '1);
    mz  = !is_div(op) &&
          ((data1 == '0) || (data2 == '0));
    val_out = neg_in ? -val_in : val_in;
  end

endmodule

// File: rtl/muldiv_iter.sv
// Iterative M-extension unit: shift-add multiply, restoring divide.
// MULDIV_EARLY_OUT_EN: special cases finish one cycle after launch.
module muldiv_iter
  import muldiv_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = $clog2(XLEN) + 1
) (
  input  logic            CLK,
  input  logic            RESET_N,
  input  logic            START,
  input  logic [2:0]      OP,
  input  logic [XLEN-1:0] DATA1,
  input  logic [XLEN-1:0] DATA2,
  input  logic            KILL,
  output logic            BUSY,
  output logic            DONE,
  output logic [XLEN-1:0] RESULT
);

`ifdef MULDIV_EARLY_OUT_EN
  localparam logic EARLY = 1'b1;
`else
  localparam logic EARLY = 1'b0;
`endif

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic [2:0]        op_q;
  logic [XLEN-1:0]   hi;
  logic [XLEN-1:0]   lo;
  logic [XLEN-1:0]   opnd;
  logic              neg_q;
  logic              sp_q;
  logic              done_q;
  logic [XLEN-1:0]   res_q;

  logic [XLEN-1:0]   a_abs;
  logic [XLEN-1:0]   b_abs;
  logic              neg;
  logic              dz;
  logic              ovf;
  logic              mz;
  logic [2*XLEN-1:0] sel;
  logic [2*XLEN-1:0] val_out;

  logic              accept;
  logic              sp;
  logic [XLEN-1:0]   spval;
  logic [XLEN:0]     sum;
  logic [XLEN:0]     tmp;
  logic [XLEN:0]     diff;
  logic [XLEN-1:0]   fixval;

  muldiv_sign_prep #(.XLEN(XLEN)) u_prep (
    .op      (OP),
    .data1   (DATA1),
    .data2   (DATA2),
    .neg_in  (neg_q),
    .val_in  (sel),
    .a_abs   (a_abs),
    .b_abs   (b_abs),
    .neg     (neg),
    .dz      (dz),
    .ovf     (ovf),
    .mz      (mz),
    .val_out (val_out)
  );

  always_comb begin
    accept = (state == S_IDLE) && START && !KILL;
    sp     = dz | ovf | (EARLY & mz);
    spval  = '0;
    if (dz)
      spval = is_rem(OP) ? DATA1 : '1;
    else if (ovf)
      spval = is_rem(OP) ? '0 : DATA1;
    sum  = {1'b0, hi} + (lo[0] ? {1'b0, opnd} : '0);
    tmp  = {hi, lo[XLEN-1]};
    diff = tmp - {1'b0, opnd};
    if (is_div(op_q))
      sel = {{XLEN{1'b0}}, is_rem(op_q) ? hi : lo};
    else
      sel = {hi, lo};
    if (!is_div(op_q) && (op_q != OP_MUL))
      fixval = val_out[2*XLEN-1:XLEN];
    else
      fixval = val_out[XLEN-1:0];
    // Special results were parked in lo at launch.
    if (sp_q)
      fixval = lo;
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state  <= S_IDLE;
      cnt    <= '0;
      op_q   <= '0;
      hi     <= '0;
      lo     <= '0;
      opnd   <= '0;
      neg_q  <= 1'b0;
      sp_q   <= 1'b0;
      done_q <= 1'b0;
      res_q  <= '0;
    end else begin
      done_q <= 1'b0;
      case (state)
        S_IDLE: begin
          if (accept) begin
            op_q  <= OP;
            neg_q <= neg;
            sp_q  <= sp;
            cnt   <= CNT_W'(XLEN);
            hi    <= '0;
            if (sp) begin
              lo    <= spval;
              opnd  <= '0;
              state <= EARLY ? S_FIX : S_CALC;
            end else if (is_div(OP)) begin
              lo    <= a_abs;
              opnd  <= b_abs;
              state <= S_CALC;
            end else begin
              lo    <= b_abs;
              opnd  <= a_abs;
              state <= S_CALC;
            end
          end
        end
        S_CALC: begin
          if (KILL) begin
            state <= S_IDLE;
          end else begin
            cnt <= cnt - CNT_W'(1);
            if (!sp_q) begin
              if (is_div(op_q)) begin
                hi <= diff[XLEN] ? tmp[XLEN-1:0]
                                 : diff[XLEN-1:0];
                lo <= {lo[XLEN-2:0], ~diff[XLEN]};
              end else begin
                hi <= sum[XLEN:1];
                lo <= {sum[0], lo[XLEN-1:1]};
              end
            end
            if (cnt == CNT_W'(1))
              state <= S_FIX;
          end
        end
        S_FIX: begin
          state <= S_IDLE;
          if (!KILL) begin
            res_q  <= fixval;
            done_q <= 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign BUSY   = (state != S_IDLE);
  assign DONE   = done_q;
  assign RESULT = res_q;

endmodule

// File: doc/muldiv_iter.md
Name: muldiv_iter

Overview:
- Parametrised, iterative RV32M/RV64M multiply/divide unit.
- Takes MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU out of the single-cycle ALU and computes them over multiple cycles, one bit per cycle (shift-add / restoring).
- Sits beside the ALU in EX. The pipeline launches with START, stalls on BUSY and captures RESULT on DONE.
- Implements full RISC-V M semantics: upper-half products, divide-by-zero and signed-overflow results.

Parameters:
- XLEN, 32, operand/result width; legal values 32 or 64.
- CNT_W, $clog2(XLEN)+1, iteration counter width (derived; do not override).

Ports:
- CLK  input  1  clock, rising edge.
- RESET_N  input  1  asynchronous active-low reset.
- START  input  1  launch request; accepted only when BUSY=0.
- OP  input  3  operation, RISC-V funct3 encoding: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- DATA1  input  XLEN  rs1 operand (multiplicand / dividend).
- DATA2  input  XLEN  rs2 operand (multiplier / divisor).
- KILL  input  1  synchronous abort (pipeline flush).
- BUSY  output  1  operation in progress.
- DONE  output  1  one-cycle pulse; RESULT valid.
- RESULT  output  XLEN  result; holds its value until the next DONE.

Behaviour:
- Reset: RESET_N is asynchronous, active-low, one clock. While low: BUSY=0, DONE=0, RESULT=0, FSM=IDLE, all datapath registers 0. Reset mid-operation discards the operation silently.
- FSM states IDLE, CALC, FIX.
  - IDLE -> CALC on START & !KILL. At edge E0 the block latches OP, |DATA1|, |DATA2| (signed per OP), the result sign and the special-case flags. BUSY rises after E0.
  - CALC runs one iteration per edge, E1..E_XLEN, counter decrementing from XLEN. Then CALC -> FIX.
  - FIX applies sign correction and selects the low/high half or quotient/remainder. At E_{XLEN+1} it registers RESULT, sets DONE=1 and BUSY=0, and returns to IDLE.
- Latency: DONE is high in the cycle following E_{XLEN+1}, i.e. XLEN+1 cycles after acceptance (33 for XLEN=32). Throughput is one operation per XLEN+2 cycles.
- START while BUSY=1 is ignored; no queueing. START may be asserted in the same cycle as DONE and is accepted.
- Multiply: 2*XLEN-bit product. MUL returns the low XLEN bits; MULH, MULHSU and MULHU return the high XLEN bits with signed×signed, signed×unsigned and unsigned×unsigned interpretation respectively.
- Divide: quotient rounds toward zero; remainder takes the sign of the dividend.
- Divide by zero:
  - DIV/DIVU: RESULT = all ones.
  - REM/REMU: RESULT = DATA1.
  - No exception is raised.
- Signed overflow (DATA1 = most-negative, DATA2 = -1):
  - DIV: RESULT = most-negative.
  - REM: RESULT = 0.
- Special cases use the full latency unless the optional feature is enabled.
- KILL:
  - In CALC/FIX: returns to IDLE at the next edge; BUSY=0, no DONE, RESULT unchanged.
  - In IDLE with START: KILL wins and nothing is accepted.
  - Has no effect on a DONE pulse already issued.
- Inputs DATA1, DATA2 and OP may change freely after acceptance.

Optional Feature:
- MULDIV_EARLY_OUT_EN defined: the following skip CALC/FIX and complete with RESULT/DONE registered at E1 (latency 1):
  - divide-by-zero;
  - signed overflow;
  - multiply with either operand zero.
- Not defined: every operation takes exactly XLEN+1 cycles. Results are identical either way.

Decomposition:
- Shared package muldiv_pkg: OP encoding localparams (OP_MUL..OP_REMU), FSM state typedef, helper function is_div(OP).
- One sub-module, muldiv_sign_prep (combinational):
  - produces operand absolute values, the result-negate flag and the special-case flags from OP/DATA1/DATA2;
  - is reused in the FIX stage for final negation.

Test Plan (XLEN=32):
- MUL 25×20 -> RESULT=500. DONE exactly 33 cycles after the START edge; BUSY high for 33 cycles.
- DATA1=DATA2=0xFFFFFFFF -> MULH=0x00000000, MULHU=0xFFFFFFFE, MULHSU=0xFFFFFFFF, MUL=0x00000001.
- DIV -7/2 -> 0xFFFFFFFD; REM -7/2 -> 0xFFFFFFFF; DIVU 25/20 -> 1; REMU 25/20 -> 5.
- DIV 25/0 -> 0xFFFFFFFF; REM 25/0 -> 25; DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM same operands -> 0. Latency is 33 cycles, or 1 with MULDIV_EARLY_OUT_EN.
- START MUL, KILL at CALC cycle 10 -> BUSY=0 next cycle, no DONE, RESULT keeps its prior value. A START pulse during BUSY is ignored.
- RESET_N low mid-CALC -> BUSY/DONE/RESULT go to 0 immediately (asynchronous). A new START after release completes normally.
